// File: rtl/proc_pkg.sv
// Shared constants and bus type for the vector processor pipeline.
//   REG_AW   : destination register index width
//   SDATA_W  : scalar ALU result width
//   VDATA_W  : vector result width (16 lanes x 8 bit)
//   mw_bus_t : packed MEM->WB payload {regw, regmem, regScr, ALUrslt, regVrslt}
package proc_pkg;

  localparam int REG_AW  = 4;
  localparam int SDATA_W = 32;
  localparam int VDATA_W = 128;

  localparam int VLANES  = 16;
  localparam int VLANE_W = VDATA_W / VLANES;

  typedef struct packed {
    logic               regw;
    logic               regmem;
    logic [REG_AW-1:0]  regScr;
    logic [SDATA_W-1:0] ALUrslt;
    logic [VDATA_W-1:0] regVrslt;
  } mw_bus_t;

  localparam int MW_BUS_W = $bits(mw_bus_t);

endpackage : proc_pkg

// File: rtl/mwpipe_pipe_reg.sv
// Generic pipeline D register with asynchronous active-low reset.
// Reset forces the stored value to zero immediately; release is seen on
// the next rising clock edge. No enable: the input is captured every cycle.
// Ports:
//   clk_i  : clock, captures on rising edge
//   rst_ni : asynchronous reset, active low
//   d_i    : data in  [W-1:0]
//   q_o    : data out [W-1:0], driven straight from the flops
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  assign data_d = d_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule : pipe_reg

// File: rtl/mwpipe.sv
// MEM->WB pipeline register of the vector processor.
// Captures memory-stage control, destination index and scalar/vector
// results and presents them to writeback one clock later. No stall, no
// flush, no transformation; data registers even when regw_M is 0.
// Ports:
//   clk        : clock, rising-edge capture
//   rst        : asynchronous reset, active low (0 = reset)
//   regw_M     : register-write enable            -> regw_W
//   regmem_M   : writeback select (1 = mem data)  -> regmem_W
//   regScr_M   : destination register index       -> regScr_W
//   ALUrslt_M  : scalar ALU result / address      -> ALUrslt_W
//   regVrslt_M : vector result                    -> regVrslt_W
module mwpipe
  import proc_pkg::*;
#(
  parameter int REG_AW  = proc_pkg::REG_AW,
  parameter int SDATA_W = proc_pkg::SDATA_W,
  parameter int VDATA_W = proc_pkg::VDATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               regw_M,
  input  logic               regmem_M,
  input  logic [REG_AW-1:0]  regScr_M,
  input  logic [SDATA_W-1:0] ALUrslt_M,
  input  logic [VDATA_W-1:0] regVrslt_M,
  output logic               regw_W,
  output logic               regmem_W,
  output logic [REG_AW-1:0]  regScr_W,
  output logic [SDATA_W-1:0] ALUrslt_W,
  output logic [VDATA_W-1:0] regVrslt_W
);

  // One register per field keeps the widths tied to this module's
  // parameters rather than to the package struct layout.
  pipe_reg #(.W(1)) u_regw (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (regw_M),
    .q_o    (regw_W)
  );

  pipe_reg #(.W(1)) u_regmem (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (regmem_M),
    .q_o    (regmem_W)
  );

  pipe_reg #(.W(REG_AW)) u_regscr (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (regScr_M),
    .q_o    (regScr_W)
  );

  pipe_reg #(.W(SDATA_W)) u_alurslt (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (ALUrslt_M),
    .q_o    (ALUrslt_W)
  );

  pipe_reg #(.W(VDATA_W)) u_regvrslt (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (regVrslt_M),
    .q_o    (regVrslt_W)
  );

endmodule : mwpipe

// File: tb/tb_mwpipe.sv
module tb_mwpipe;

  localparam int REG_AW  = 4;
  localparam int SDATA_W = 32;
  localparam int VDATA_W = 128;

  logic               clk;
  logic               rst;
  logic               regw_M;
  logic               regmem_M;
  logic [REG_AW-1:0]  regScr_M;
  logic [SDATA_W-1:0] ALUrslt_M;
  logic [VDATA_W-1:0] regVrslt_M;
  logic               regw_W;
  logic               regmem_W;
  logic [REG_AW-1:0]  regScr_W;
  logic [SDATA_W-1:0] ALUrslt_W;
  logic [VDATA_W-1:0] regVrslt_W;

  int checks;
  int failures;

  localparam logic [VDATA_W-1:0] VEC_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [VDATA_W-1:0] VEC_B = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;

  mwpipe dut (
    .clk        (clk),
    .rst        (rst),
    .regw_M     (regw_M),
    .regmem_M   (regmem_M),
    .regScr_M   (regScr_M),
    .ALUrslt_M  (ALUrslt_M),
    .regVrslt_M (regVrslt_M),
    .regw_W     (regw_W),
    .regmem_W   (regmem_W),
    .regScr_W   (regScr_W),
    .ALUrslt_W  (ALUrslt_W),
    .regVrslt_W (regVrslt_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_all(input string tag,
                           input logic               e_regw,
                           input logic               e_regmem,
                           input logic [REG_AW-1:0]  e_scr,
                           input logic [SDATA_W-1:0] e_alu,
                           input logic [VDATA_W-1:0] e_vec);
    checks++;
    assert (regw_W === e_regw) else begin
      failures++;
      $error("FAIL %s.regw_W observed=%b expected=%b", tag, regw_W, e_regw);
    end
    checks++;
    assert (regmem_W === e_regmem) else begin
      failures++;
      $error("FAIL %s.regmem_W observed=%b expected=%b", tag, regmem_W, e_regmem);
    end
    checks++;
    assert (regScr_W === e_scr) else begin
      failures++;
      $error("FAIL %s.regScr_W observed=%h expected=%h", tag, regScr_W, e_scr);
    end
    checks++;
    assert (ALUrslt_W === e_alu) else begin
      failures++;
      $error("FAIL %s.ALUrslt_W observed=%h expected=%h", tag, ALUrslt_W, e_alu);
    end
    checks++;
    assert (regVrslt_W === e_vec) else begin
      failures++;
      $error("FAIL %s.regVrslt_W observed=%h expected=%h", tag, regVrslt_W, e_vec);
    end
  endtask

  task automatic drive(input logic w, input logic m, input logic [REG_AW-1:0] s,
                       input logic [SDATA_W-1:0] a, input logic [VDATA_W-1:0] v);
    regw_M     = w;
    regmem_M   = m;
    regScr_M   = s;
    ALUrslt_M  = a;
    regVrslt_M = v;
  endtask

  // Rising edges fall at 5, 15, 25, ...; after_edge leaves time at edge+1.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset held with nonzero inputs: outputs zero at once and across edges.
    rst = 1'b0;
    drive(1'b1, 1'b1, 4'hF, 32'hDEADBEEF, VEC_B);
    #1;
    check_all("reset_immediate", 1'b0, 1'b0, 4'h0, 32'h0, '0);
    for (int i = 0; i < 3; i++) begin
      after_edge();
      check_all("reset_hold", 1'b0, 1'b0, 4'h0, 32'h0, '0);
    end

    // Release between edges, then single transfer.
    #2;
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'b0011, 32'h0000FFFF, '0);
    #2;
    check_all("release_no_capture_yet", 1'b0, 1'b0, 4'h0, 32'h0, '0);
    after_edge();
    check_all("single_transfer", 1'b1, 1'b0, 4'h3, 32'h0000FFFF, '0);

    // Back-to-back: only the destination index moves.
    drive(1'b1, 1'b0, 4'b0100, 32'h0000FFFF, '0);
    #7;
    check_all("b2b_before_edge", 1'b1, 1'b0, 4'h3, 32'h0000FFFF, '0);
    after_edge();
    check_all("b2b_after_edge", 1'b1, 1'b0, 4'h4, 32'h0000FFFF, '0);

    // Vector path with memory writeback select.
    drive(1'b1, 1'b1, 4'b0100, 32'h0000FFFF, VEC_A);
    #7;
    check_all("vec_before_edge", 1'b1, 1'b0, 4'h4, 32'h0000FFFF, '0);
    after_edge();
    check_all("vec_after_edge", 1'b1, 1'b1, 4'h4, 32'h0000FFFF, VEC_A);

    // regw low must not mask data.
    drive(1'b0, 1'b0, 4'hA, 32'h1357_9BDF, VEC_B);
    after_edge();
    check_all("regw0_data_passes", 1'b0, 1'b0, 4'hA, 32'h1357_9BDF, VEC_B);

    // Async reset mid-cycle while outputs are nonzero.
    drive(1'b1, 1'b1, 4'h7, 32'hCAFE_F00D, VEC_A);
    #2;
    rst = 1'b0;
    #1;
    check_all("async_reset_midcycle", 1'b0, 1'b0, 4'h0, 32'h0, '0);
    after_edge();
    check_all("async_reset_over_edge", 1'b0, 1'b0, 4'h0, 32'h0, '0);
    #3;
    rst = 1'b1;
    #3;
    check_all("release_waits_for_edge", 1'b0, 1'b0, 4'h0, 32'h0, '0);
    after_edge();
    check_all("recapture_after_release", 1'b1, 1'b1, 4'h7, 32'hCAFE_F00D, VEC_A);

    // Inputs toggling between edges must not reach the outputs.
    drive(1'b0, 1'b0, 4'h1, 32'h1111_1111, VEC_B);
    #2;
    check_all("glitch_a", 1'b1, 1'b1, 4'h7, 32'hCAFE_F00D, VEC_A);
    drive(1'b1, 1'b0, 4'hE, 32'h8000_0001, ~VEC_A);
    #3;
    check_all("glitch_b", 1'b1, 1'b1, 4'h7, 32'hCAFE_F00D, VEC_A);
    after_edge();
    check_all("glitch_settled", 1'b1, 1'b0, 4'hE, 32'h8000_0001, ~VEC_A);

    // All-ones boundary pattern, then all zeros.
    drive(1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF, {VDATA_W{1'b1}});
    after_edge();
    check_all("all_ones", 1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF, {VDATA_W{1'b1}});
    drive(1'b0, 1'b0, 4'h0, 32'h0, '0);
    after_edge();
    check_all("all_zeros", 1'b0, 1'b0, 4'h0, 32'h0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mwpipe
